// File: rtl/tinycpu_pkg.sv
// Shared definitions for the tinycpu front end: fetch FSM encodings,
// reset PC default and the instruction word width.
package tinycpu_pkg;

    localparam int unsigned INSTR_W          = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;

    typedef enum logic [1:0] {
        FETCH_ISSUE = 2'd0,
        FETCH_WAIT  = 2'd1,
        FETCH_HOLD  = 2'd2
    } fetch_state_e;

    // Branch targets are word aligned; the low two bits are simply dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'd3;
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Front pipeline stage: keeps the PC, fetches one word per instruction over a
// req/ack memory bus and hands it to the decoder with the DOR/ack handshake.
module instruction_fetch
    import tinycpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               DOR,
    output logic [INSTR_W-1:0] data_out,
    output logic [31:0]        pc_out,
    input  logic               ack_from_next,
    output logic [31:0]        fetch_count
);

    fetch_state_e       state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        pending_pc_q, pending_pc_d;
    logic               kill_q, kill_d;
    logic               imem_req_q, imem_req_d;
    logic [31:0]        imem_addr_q, imem_addr_d;
    logic               dor_q, dor_d;
    logic [INSTR_W-1:0] data_out_q, data_out_d;
    logic [31:0]        pc_out_q, pc_out_d;
    logic [31:0]        count_q, count_d;
    logic [31:0]        redirect_aligned;

    assign redirect_aligned = align_pc(redirect_pc);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pending_pc_d = pending_pc_q;
        kill_d       = kill_q;
        imem_req_d   = imem_req_q;
        imem_addr_d  = imem_addr_q;
        dor_d        = dor_q;
        data_out_d   = data_out_q;
        pc_out_d     = pc_out_q;

        case (state_q)
            FETCH_ISSUE: begin
                imem_req_d  = 1'b1;
                imem_addr_d = pc_q;
                state_d     = FETCH_WAIT;
                if (redirect_valid) begin
                    pc_d        = redirect_aligned;
                    imem_addr_d = redirect_aligned;
                end
            end
            FETCH_WAIT: begin
                // The bus cannot be aborted, so a redirect only marks the word for discard.
                if (imem_ack) begin
                    imem_req_d = 1'b0;
                    if (kill_q || redirect_valid) begin
                        kill_d  = 1'b0;
                        pc_d    = redirect_valid ? redirect_aligned : pending_pc_q;
                        state_d = FETCH_ISSUE;
                    end else begin
                        data_out_d = imem_data;
                        pc_out_d   = pc_q;
                        pc_d       = pc_q + PC_STEP;
                        dor_d      = 1'b1;
                        state_d    = FETCH_HOLD;
                    end
                end else if (redirect_valid) begin
                    kill_d       = 1'b1;
                    pending_pc_d = redirect_aligned;
                end
            end
            FETCH_HOLD: begin
                if (ack_from_next || redirect_valid) begin
                    dor_d   = 1'b0;
                    state_d = FETCH_ISSUE;
                end
                if (redirect_valid) begin
                    pc_d = redirect_aligned;
                end
            end
            default: begin
                state_d = FETCH_ISSUE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= FETCH_ISSUE;
            pc_q         <= RESET_PC;
            pending_pc_q <= 32'd0;
            kill_q       <= 1'b0;
            imem_req_q   <= 1'b0;
            imem_addr_q  <= 32'd0;
            dor_q        <= 1'b0;
            data_out_q   <= '0;
            pc_out_q     <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pending_pc_q <= pending_pc_d;
            kill_q       <= kill_d;
            imem_req_q   <= imem_req_d;
            imem_addr_q  <= imem_addr_d;
            dor_q        <= dor_d;
            data_out_q   <= data_out_d;
            pc_out_q     <= pc_out_d;
        end
    end

    // A word counts as delivered only when the decoder acks it in HOLD.
    always_comb begin
        count_d = count_q;
        if (state_q == FETCH_HOLD && ack_from_next) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign DOR         = dor_q;
    assign data_out    = data_out_q;
    assign pc_out      = pc_out_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed and randomized checks of instruction_fetch against a simple
// PC/count model and an address-hashed instruction memory.
module tb_instruction_fetch;

    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        DOR;
    logic [31:0] data_out;
    logic [31:0] pc_out;
    logic        ack_from_next;
    logic [31:0] fetch_count;

    int          errors;
    int          checks;
    logic [31:0] mPc;
    logic [31:0] mCount;
    logic [31:0] lastPc;

    instruction_fetch dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .DOR            (DOR),
        .data_out       (data_out),
        .pc_out         (pc_out),
        .ack_from_next  (ack_from_next),
        .fetch_count    (fetch_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory contents: any address maps to a distinct word, 0x0 holds 0x20.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a * 32'h9E37_79B9 + 32'h20;
    endfunction

    function automatic logic [31:0] randTarget();
        if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
        return $urandom;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkZeroOutputs(input string tag);
        checkOutput({tag, ".req"},   32'(imem_req), 32'd0);
        checkOutput({tag, ".addr"},  imem_addr,     32'd0);
        checkOutput({tag, ".dor"},   32'(DOR),      32'd0);
        checkOutput({tag, ".data"},  data_out,      32'd0);
        checkOutput({tag, ".pcout"}, pc_out,        32'd0);
        checkOutput({tag, ".count"}, fetch_count,   32'd0);
    endtask

    // Precondition: request outstanding at mPc. Memory answers after lat idle cycles.
    task automatic serveFetch(input int lat);
        checkOutput("serve.req", 32'(imem_req), 32'd1);
        checkOutput("serve.addr", imem_addr, mPc);
        for (int i = 0; i < lat; i++) begin
            applyStimulus();
            checkOutput("wait.req", 32'(imem_req), 32'd1);
            checkOutput("wait.addr", imem_addr, mPc);
            checkOutput("wait.dor", 32'(DOR), 32'd0);
        end
        imem_ack  = 1'b1;
        imem_data = memWord(mPc);
        applyStimulus();
        imem_ack  = 1'b0;
        imem_data = $urandom;
        checkOutput("deliver.dor", 32'(DOR), 32'd1);
        checkOutput("deliver.req", 32'(imem_req), 32'd0);
        checkOutput("deliver.data", data_out, memWord(mPc));
        checkOutput("deliver.pc", pc_out, mPc);
        lastPc = mPc;
        mPc    = mPc + 32'd4;
    endtask

    // Precondition: DOR=1. Hold for some cycles, then release by ack and/or redirect.
    task automatic consume(input int hold, input bit ackIt, input bit redir, input logic [31:0] target,
                           input bit issueRedir, input logic [31:0] issueTarget);
        for (int i = 0; i < hold; i++) begin
            applyStimulus();
            checkOutput("hold.dor", 32'(DOR), 32'd1);
            checkOutput("hold.data", data_out, memWord(lastPc));
            checkOutput("hold.pc", pc_out, lastPc);
            checkOutput("hold.req", 32'(imem_req), 32'd0);
        end
        ack_from_next  = ackIt;
        redirect_valid = redir;
        redirect_pc    = target;
        applyStimulus();
        ack_from_next  = 1'b0;
        redirect_valid = 1'b0;
        if (ackIt) mCount = mCount + 32'd1;
        if (redir) mPc = target & ~32'd3;
        checkOutput("release.dor", 32'(DOR), 32'd0);
        checkOutput("release.count", fetch_count, mCount);
        checkOutput("release.req", 32'(imem_req), 32'd0);
        if (issueRedir) begin
            redirect_valid = 1'b1;
            redirect_pc    = issueTarget;
            mPc            = issueTarget & ~32'd3;
        end
        applyStimulus();
        redirect_valid = 1'b0;
        checkOutput("issue.req", 32'(imem_req), 32'd1);
        checkOutput("issue.addr", imem_addr, mPc);
        checkOutput("issue.dor", 32'(DOR), 32'd0);
    endtask

    // Precondition: request outstanding at mPc. A redirect makes the returned word void.
    task automatic killFetch(input int lat, input bit coincident, input bit overwrite,
                             input logic [31:0] t1, input logic [31:0] t2);
        logic [31:0] target;
        checkOutput("kill.req", 32'(imem_req), 32'd1);
        checkOutput("kill.addr", imem_addr, mPc);
        target = t1;
        if (!coincident) begin
            redirect_valid = 1'b1;
            redirect_pc    = t1;
            applyStimulus();
            redirect_valid = 1'b0;
            checkOutput("kill.holdreq", 32'(imem_req), 32'd1);
            checkOutput("kill.holdaddr", imem_addr, mPc);
            if (overwrite) begin
                redirect_valid = 1'b1;
                redirect_pc    = t2;
                target         = t2;
                applyStimulus();
                redirect_valid = 1'b0;
                checkOutput("kill.ovrreq", 32'(imem_req), 32'd1);
            end
        end
        for (int i = 0; i < lat; i++) begin
            applyStimulus();
            checkOutput("kill.waitreq", 32'(imem_req), 32'd1);
            checkOutput("kill.waitdor", 32'(DOR), 32'd0);
        end
        imem_ack  = 1'b1;
        imem_data = memWord(mPc);
        if (coincident) begin
            redirect_valid = 1'b1;
            redirect_pc    = t1;
        end
        applyStimulus();
        imem_ack       = 1'b0;
        redirect_valid = 1'b0;
        checkOutput("kill.dor", 32'(DOR), 32'd0);
        checkOutput("kill.reqdrop", 32'(imem_req), 32'd0);
        mPc = target & ~32'd3;
        applyStimulus();
        checkOutput("kill.nextreq", 32'(imem_req), 32'd1);
        checkOutput("kill.nextaddr", imem_addr, mPc);
        checkOutput("kill.nextdor", 32'(DOR), 32'd0);
    endtask

    initial begin
        int mode;
        int sel;
        errors         = 0;
        checks         = 0;
        mPc            = 32'd0;
        mCount         = 32'd0;
        lastPc         = 32'd0;
        reset_n        = 1'b0;
        imem_ack       = 1'b0;
        imem_data      = 32'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        ack_from_next  = 1'b0;

        // Reset state, then first fetch from 0x0.
        repeat (2) @(posedge clk);
        #1;
        checkZeroOutputs("reset");
        reset_n = 1'b1;
        applyStimulus();
        serveFetch(0);
        consume(0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);

        // Slow memory at 0x4.
        serveFetch(5);
        consume(0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);

        // Redirect to 0x103 while waiting at 0x8.
        killFetch(0, 1'b0, 1'b0, 32'h0000_0103, 32'd0);
        checkOutput("t3.addr", imem_addr, 32'h0000_0100);

        // Redirect and ack together in HOLD.
        serveFetch(0);
        consume(0, 1'b1, 1'b1, 32'h0000_0040, 1'b0, 32'd0);

        // Decoder stalls for 10 cycles.
        serveFetch(1);
        consume(10, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);

        // Reset pulse during WAIT, with a stale ack right after release.
        reset_n = 1'b0;
        #1;
        checkZeroOutputs("midreset");
        mPc    = 32'd0;
        mCount = 32'd0;
        applyStimulus();
        checkZeroOutputs("midreset.hold");
        reset_n   = 1'b1;
        imem_ack  = 1'b1;
        imem_data = 32'hDEAD_BEEF;
        applyStimulus();
        imem_ack  = 1'b0;
        checkOutput("restart.req", 32'(imem_req), 32'd1);
        checkOutput("restart.addr", imem_addr, 32'd0);
        checkOutput("restart.dor", 32'(DOR), 32'd0);
        serveFetch(0);
        checkOutput("restart.data", data_out, 32'h0000_0020);
        consume(0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);

        // Randomized mix of plain fetches, WAIT kills, HOLD and ISSUE redirects.
        for (int n = 0; n < 80; n++) begin
            mode = int'($urandom_range(0, 3));
            if (mode == 0) begin
                killFetch(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), randTarget(), randTarget());
            end else begin
                serveFetch(int'($urandom_range(0, 3)));
                sel = int'($urandom_range(0, 2));
                consume(int'($urandom_range(0, 3)), sel != 1, sel != 0, randTarget(),
                        $urandom_range(0, 3) == 0, randTarget());
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
